// File: rtl/uart_tx_unit.sv
// ============================================================================
// uart_tx_unit
// ----------------------------------------------------------------------------
// Asynchronous serial transmitter. It is the companion of the 16x-oversampled
// UART receiver and shares its baud tick. A parallel word is sent as one start
// bit (0), DBIT data bits LSB first, an optional even-parity bit, and a stop
// period of SB_TICK baud ticks (1).
//
// Optional feature (compile-time macro):
//   UART_TX_PARITY_EN  - when defined, a PARITY state of 16 ticks is inserted
//                        between DATA and STOP. It carries even parity over
//                        the data word captured at accept.
//
// Parameters:
//   DBIT     - data bits per frame (5..9)
//   SB_TICK  - stop period in s_tick units (16 = 1, 24 = 1.5, 32 = 2 bits)
//
// Ports:
//   clk           in   system clock, rising-edge active
//   reset_n       in   asynchronous active-low reset
//   s_tick        in   baud enable, one clk wide, 16 per bit period
//   tx_start      in   request to send din (looked at only while idle)
//   din           in   word to send, captured on the accepting edge
//   tx_done_tick  out  one-clk pulse during the last tick of the stop period
//   tx_busy       out  high whenever the FSM is not idle
//   tx            out  registered serial line, idles high
//
// Handshake: tx_start acts as "valid" and ~tx_busy as "ready". A word is
// accepted on a rising clk edge where tx_start=1 and the FSM is idle. Requests
// made while busy are dropped, not queued, and din is not looked at again
// until the next accept. tx_done_tick is high in the final STOP cycle, while
// tx_busy is still high, so a request in that same cycle is dropped too.
// ============================================================================
module uart_tx_unit #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            s_tick,
    input  logic            tx_start,
    input  logic [DBIT-1:0] din,
    output logic            tx_done_tick,
    output logic            tx_busy,
    output logic            tx
);

    // Bit counter width: ceil(log2(DBIT)), with a minimum of 1.
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [4:0]    S_BIT_LAST  = 5'd15;
    localparam logic [4:0]    S_STOP_LAST = 5'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;
`endif

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    state_t          state;
    logic [4:0]      s;        // tick count inside the current bit
    logic [NW-1:0]   n;        // data bit index
    logic [DBIT-1:0] b;        // shift register, b[0] is on the line
    logic            busy_q;
    logic            tx_q;
`ifdef UART_TX_PARITY_EN
    logic            par_q;    // even parity of the captured word
`endif

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    state_t          state_n;
    logic [4:0]      s_n;
    logic [NW-1:0]   n_n;
    logic [DBIT-1:0] b_n;
    logic            tx_n;
    logic            done_c;
`ifdef UART_TX_PARITY_EN
    logic            par_n;
`endif

    always_comb begin
        state_n = state;
        s_n     = s;
        n_n     = n;
        b_n     = b;
        done_c  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_n   = par_q;
`endif

        unique case (state)
            IDLE: begin
                // s_tick is ignored while idle, so s stays where reset or
                // the previous frame left it until the next accept.
                if (tx_start) begin
                    state_n = START;
                    s_n     = 5'd0;
                    b_n     = din;
`ifdef UART_TX_PARITY_EN
                    par_n   = ^din;
`endif
                end
            end

            START: begin
                if (s_tick) begin
                    if (s == S_BIT_LAST) begin
                        state_n = DATA;
                        s_n     = 5'd0;
                        n_n     = '0;
                    end else begin
                        s_n = s + 5'd1;
                    end
                end
            end

            DATA: begin
                if (s_tick) begin
                    if (s == S_BIT_LAST) begin
                        s_n = 5'd0;
                        b_n = b >> 1;
                        if (n == N_LAST) begin
`ifdef UART_TX_PARITY_EN
                            state_n = PARITY;
`else
                            state_n = STOP;
`endif
                        end else begin
                            n_n = n + 1'b1;
                        end
                    end else begin
                        s_n = s + 5'd1;
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (s == S_BIT_LAST) begin
                        state_n = STOP;
                        s_n     = 5'd0;
                    end else begin
                        s_n = s + 5'd1;
                    end
                end
            end
`endif

            STOP: begin
                if (s_tick) begin
                    if (s == S_STOP_LAST) begin
                        state_n = IDLE;
                        s_n     = 5'd0;
                        done_c  = 1'b1;
                    end else begin
                        s_n = s + 5'd1;
                    end
                end
            end

            default: begin
                state_n = IDLE;
                s_n     = 5'd0;
            end
        endcase

        // The line level is a function of the state being entered, so the
        // tx flop changes on the same edge as the state it belongs to. This
        // is what gives one clk from accept to the start-bit falling edge.
        unique case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = b_n[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_n = par_n;
`endif
            default: tx_n = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Sequential update
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            s      <= 5'd0;
            n      <= '0;
            b      <= '0;
            busy_q <= 1'b0;
            tx_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q  <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            s      <= s_n;
            n      <= n_n;
            b      <= b_n;
            busy_q <= (state_n != IDLE);
            tx_q   <= tx_n;
`ifdef UART_TX_PARITY_EN
            par_q  <= par_n;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign tx      = tx_q;
    assign tx_busy = busy_q;

    // The done pulse has to be high in the final STOP cycle itself (the FSM
    // is still in STOP, so a same-cycle request is ignored). That cycle is
    // only known once s_tick arrives, so the pulse is decoded from the
    // registered state, the registered counter and s_tick.
    assign tx_done_tick = done_c;

endmodule

// File: tb/tb_uart_tx_unit.sv
// ============================================================================
// tb_uart_tx_unit
// ----------------------------------------------------------------------------
// Bench for uart_tx_unit with a scoreboard. The driver pushes each expected
// word, with its hand-computed parity, onto exp_q. The monitor watches the
// serial line. On every start-bit falling edge it pops one entry, builds the
// bit sequence the line must carry, and checks every clk of the frame. It also
// checks tx_busy through the frame and the exact cycle of tx_done_tick.
// Build with +define+UART_TX_PARITY_EN to exercise the parity build.
// ============================================================================
module tb_uart_tx_unit;

  localparam int DBIT = 8;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NBITS = 2 + DBIT + PAR;  // start + data + parity + stop

  logic            clk;
  logic            reset_n;
  logic            s_tick;
  logic            tx_start;
  logic [DBIT-1:0] din;
  logic            tx_done_tick;
  logic            tx_busy;
  logic            tx;

  int checks = 0;
  int errors = 0;
  int frames_done = 0;
  int frames_started = 0;
  int last_gap = 0;
  int tick_div = 1;
  int tick_cnt = 0;

  logic [8:0] exp_q[$];  // {parity, data}

  uart_tx_unit #(.DBIT(DBIT), .SB_TICK(16)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .s_tick       (s_tick),
    .tx_start     (tx_start),
    .din          (din),
    .tx_done_tick (tx_done_tick),
    .tx_busy      (tx_busy),
    .tx           (tx)
  );

  // --------------------------------------------------------------------------
  // Clock and baud tick
  // --------------------------------------------------------------------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // s_tick is high once every tick_div clks; it changes on the falling edge.
  initial begin
    s_tick = 1'b1;
    forever begin
      @(negedge clk);
      if (tick_cnt >= tick_div - 1) tick_cnt = 0;
      else tick_cnt++;
      s_tick = (tick_cnt == tick_div - 1);
    end
  end

  // --------------------------------------------------------------------------
  // Common helpers
  // --------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // The driver acts 1 time unit after each falling edge.
  task automatic wait_clk();
    @(negedge clk);
    #1;
  endtask

  // Issue one word. tx_start is raised in a cycle where s_tick is also high,
  // so the first baud tick of the frame comes tick_div clks after the accept.
  task automatic send(input logic [7:0] d, input logic p);
    int k;
    exp_q.push_back({p, d});
    k = 0;
    while (s_tick !== 1'b1 && k < 100) begin
      wait_clk();
      k++;
    end
    tx_start = 1'b1;
    din      = d;
    wait_clk();
    tx_start = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    int k;
    k = 0;
    while (frames_done < target && k < 5000) begin
      wait_clk();
      k++;
    end
    checks++;
    if (frames_done < target) begin
      errors++;
      $display("FAIL frame_timeout actual=%0d expected=%0d", frames_done, target);
    end
  endtask

  // --------------------------------------------------------------------------
  // Monitor / scoreboard (samples 3 time units after each falling edge)
  // --------------------------------------------------------------------------
  logic        in_frame = 1'b0;
  logic        skip = 1'b0;
  logic        bit_bad, busy_bad, done_bad;
  logic [11:0] pat;
  logic [8:0]  ent;
  int          c, bl, flen, idx, gap;

  initial begin
    gap = 0;
    bit_bad = 1'b0;
    busy_bad = 1'b0;
    done_bad = 1'b0;
    forever begin
      @(negedge clk);
      #3;
      if (reset_n !== 1'b1) begin
        // A reset aborts whatever frame was in flight.
        in_frame = 1'b0;
        gap      = 0;
      end else begin
        if (!in_frame) begin
          if (tx === 1'b0) begin
            in_frame = 1'b1;
            c        = 0;
            bl       = 16 * tick_div;
            flen     = NBITS * bl;
            bit_bad  = 1'b0;
            busy_bad = 1'b0;
            done_bad = 1'b0;
            last_gap = gap;
            frames_started++;
            if (exp_q.size() == 0) begin
              skip = 1'b1;
              checks++;
              errors++;
              $display("FAIL unexpected_frame actual=start expected=idle");
            end else begin
              skip = 1'b0;
              ent  = exp_q.pop_front();
              pat  = '1;
              pat[0] = 1'b0;
              for (int i = 0; i < DBIT; i++) pat[1 + i] = ent[i];
              if (PAR == 1) pat[1 + DBIT] = ent[8];
            end
          end else begin
            gap++;
            check("idle_busy_done", {30'd0, tx_busy, tx_done_tick}, 32'd0);
          end
        end

        if (in_frame) begin
          c++;
          idx = (c - 1) / bl;
          if (!skip && tx !== pat[idx]) bit_bad = 1'b1;
          if (tx_busy !== 1'b1) busy_bad = 1'b1;
          if (c != flen && tx_done_tick !== 1'b0) done_bad = 1'b1;
          if (c % bl == 0) begin
            if (!skip) begin
              checks++;
              if (bit_bad) begin
                errors++;
                $display("FAIL frame%0d_bit%0d actual=%b expected=%b",
                         frames_started, idx, ~pat[idx], pat[idx]);
              end
            end
            bit_bad = 1'b0;
          end
          if (c == flen) begin
            check($sformatf("frame%0d_done_at_end", frames_started), {31'd0, tx_done_tick}, 32'd1);
            check($sformatf("frame%0d_done_early", frames_started), {31'd0, done_bad}, 32'd0);
            check($sformatf("frame%0d_busy_gap", frames_started), {31'd0, busy_bad}, 32'd0);
            in_frame = 1'b0;
            gap      = 0;
            frames_done++;
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Driver: directed tests
  // --------------------------------------------------------------------------
  initial begin
    // Reset held low with a pending request.
    reset_n  = 1'b0;
    tx_start = 1'b1;
    din      = 8'h96;
    repeat (3) wait_clk();
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, tx_busy}, 32'd0);
    check("rst_done", {31'd0, tx_done_tick}, 32'd0);

    // The request is accepted on the first edge after release.
    exp_q.push_back({1'b0, 8'h96});
    reset_n = 1'b1;
    wait_clk();
    tx_start = 1'b0;
    check("accept_tx_low", {31'd0, tx}, 32'd0);
    check("accept_busy", {31'd0, tx_busy}, 32'd1);
    wait_frames(1);

    // Basic frames, tick every clk. 0xA5: four ones, parity 0. 0x07: parity 1.
    repeat (5) wait_clk();
    send(8'hA5, 1'b0);
    wait_frames(2);
    send(8'h07, 1'b1);
    wait_frames(3);

    // Sparse tick: one s_tick every 4 clks, 64 clks per bit.
    tick_div = 4;
    repeat (8) wait_clk();
    send(8'h00, 1'b0);
    wait_frames(4);
    tick_div = 1;
    repeat (4) wait_clk();

    // A request in mid-frame must not disturb the frame or queue another one.
    send(8'h3C, 1'b0);
    repeat (50) wait_clk();
    tx_start = 1'b1;
    din      = 8'hFF;
    wait_clk();
    tx_start = 1'b0;
    din      = 8'h00;
    wait_frames(5);
    repeat (20) wait_clk();
    check("busy_request_dropped", frames_started, 32'd5);

    // Back-to-back: tx_start held through the done pulse; din changes mid-frame.
    exp_q.push_back({1'b0, 8'h5A});
    exp_q.push_back({1'b0, 8'hC3});
    tx_start = 1'b1;
    din      = 8'h5A;
    wait_clk();
    din = 8'hC3;
    wait_frames(6);
    wait_clk();
    tx_start = 1'b0;
    wait_frames(7);
    check("b2b_idle_gap", last_gap, 32'd1);

    // Reset in data bit 3 (frame clk 73): the line must go high with no clock.
    send(8'h6E, 1'b1);
    repeat (71) wait_clk();
    @(negedge clk);
    #4;
    reset_n = 1'b0;
    #1;
    check("abort_tx", {31'd0, tx}, 32'd1);
    check("abort_busy", {31'd0, tx_busy}, 32'd0);
    check("abort_done", {31'd0, tx_done_tick}, 32'd0);
    repeat (3) wait_clk();
    reset_n = 1'b1;
    repeat (2) wait_clk();
    check("abort_no_done_count", frames_done, 32'd7);
    send(8'h81, 1'b0);
    wait_frames(8);
    repeat (10) wait_clk();

    check("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
